// File: rtl/eth_capture_ring_ctrl.sv
// Capture slot-ring manager: grants fixed-size receive slots to the capture DMA
// and queues completed slots, in arrival order, for software to consume and free.
module eth_capture_ring_ctrl #(
  parameter int          SLOTS      = 16,
  parameter int          SLOT_BYTES = 2048,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          LEN_W      = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     cap_req,
  output logic                     cap_grant,
  output logic [31:0]              cap_addr,
  output logic                     cap_drop,
  input  logic                     cap_done,
  input  logic                     cap_abort,
  input  logic [LEN_W-1:0]         cap_len,
  input  logic                     cap_err,
  output logic                     sw_valid,
  output logic [31:0]              sw_addr,
  output logic [LEN_W-1:0]         sw_len,
  output logic                     sw_err,
  input  logic                     sw_pop,
  output logic [$clog2(SLOTS):0]   ready_count,
  output logic [31:0]              pkt_count,
  output logic [31:0]              drop_count
);

  localparam int PTR_W = $clog2(SLOTS);
  localparam int CNT_W = PTR_W + 1;
  localparam int SLOT_SHIFT = $clog2(SLOT_BYTES);
  localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);
  localparam logic [LEN_W-1:0] SLOT_LEN = LEN_W'(SLOT_BYTES);

  typedef enum logic {IDLE, FILL} ringState_t;

  ringState_t       r_state;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_readyCount;
  logic             r_grant;
  logic             r_drop;
  logic [31:0]      r_addr;
  logic [31:0]      r_pktCount;
  logic [31:0]      r_dropCount;
  logic [LEN_W-1:0] r_lenTable [SLOTS];
  logic             r_errTable [SLOTS];

  logic             w_pop;
  logic             w_commit;
  logic             w_lenClamp;
  logic [LEN_W-1:0] w_storeLen;
  logic             w_storeErr;
  logic [31:0]      w_wrAddr;

  assign w_pop      = sw_pop && (r_readyCount != '0);
  assign w_commit   = (r_state == FILL) && cap_done;
  assign w_lenClamp = cap_len > SLOT_LEN;
  assign w_storeLen = w_lenClamp ? SLOT_LEN : cap_len;
  assign w_storeErr = cap_err | w_lenClamp;
  assign w_wrAddr   = BASE_ADDR + (32'(r_wrPtr) << SLOT_SHIFT);

  // Length/error table has no reset: an entry is only visible once committed.
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      r_lenTable[r_wrPtr] <= w_storeLen;
      r_errTable[r_wrPtr] <= w_storeErr;
    end
  end

  // Grant/drop FSM, ring pointers and counters; the slot under fill is always
  // rd_ptr + ready_count, so refusing grants at a full ring protects queued data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_readyCount <= '0;
      r_grant      <= 1'b0;
      r_drop       <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_pktCount   <= '0;
      r_dropCount  <= '0;
    end else begin
      r_grant <= 1'b0;
      r_drop  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cap_req) begin
            if (enable && (r_readyCount < SLOTS_CNT)) begin
              r_grant <= 1'b1;
              r_addr  <= w_wrAddr;
              r_state <= FILL;
            end else begin
              r_drop <= 1'b1;
              if (r_dropCount != 32'hFFFF_FFFF) r_dropCount <= r_dropCount + 32'd1;
            end
          end
        end
        FILL: begin
          if (cap_done) begin
            r_wrPtr    <= r_wrPtr + PTR_W'(1);
            r_pktCount <= r_pktCount + 32'd1;
            r_state    <= IDLE;
          end else if (cap_abort) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      case ({w_commit, w_pop})
        2'b10:   r_readyCount <= r_readyCount + CNT_W'(1);
        2'b01:   r_readyCount <= r_readyCount - CNT_W'(1);
        default: r_readyCount <= r_readyCount;
      endcase
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
    end
  end

  assign cap_grant   = r_grant;
  assign cap_drop    = r_drop;
  assign cap_addr    = r_addr;
  assign sw_valid    = (r_readyCount != '0);
  assign sw_addr     = BASE_ADDR + (32'(r_rdPtr) << SLOT_SHIFT);
  assign sw_len      = r_lenTable[r_rdPtr];
  assign sw_err      = r_errTable[r_rdPtr];
  assign ready_count = r_readyCount;
  assign pkt_count   = r_pktCount;
  assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_eth_capture_ring_ctrl.sv
// Bench for eth_capture_ring_ctrl: directed steps then random traffic, each cycle
// checked against a queue-based model of the slot ring.
module tb_eth_capture_ring_ctrl;

  localparam int          SLOTS = 16;
  localparam int          SB    = 2048;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cap_req;
  logic        cap_grant;
  logic [31:0] cap_addr;
  logic        cap_drop;
  logic        cap_done;
  logic        cap_abort;
  logic [11:0] cap_len;
  logic        cap_err;
  logic        sw_valid;
  logic [31:0] sw_addr;
  logic [11:0] sw_len;
  logic        sw_err;
  logic        sw_pop;
  logic [4:0]  ready_count;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  eth_capture_ring_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .cap_req(cap_req),
    .cap_grant(cap_grant), .cap_addr(cap_addr), .cap_drop(cap_drop),
    .cap_done(cap_done), .cap_abort(cap_abort), .cap_len(cap_len), .cap_err(cap_err),
    .sw_valid(sw_valid), .sw_addr(sw_addr), .sw_len(sw_len), .sw_err(sw_err),
    .sw_pop(sw_pop), .ready_count(ready_count), .pkt_count(pkt_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: software-visible queue of completed slots plus the slot index at its head.
  int          qSlot[$];
  int          qLen[$];
  int          qErr[$];
  int          mHead;
  bit          mFill;
  logic [31:0] mPkt;
  logic [31:0] mDrop;
  bit          eGrant;
  bit          eDrop;
  logic [31:0] eAddr;
  logic [31:0] savedAddr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slotAddr(input int idx);
    return BASE + 32'(idx * SB);
  endfunction

  // One clock cycle: inputs are held across the rising edge, the model advances,
  // outputs are checked at the falling edge, then single-cycle pulses are cleared.
  task automatic applyStimulus();
    int size;
    int tail;
    int l;
    int e;
    bit wasFill;
    @(posedge clk);
    eGrant = 0;
    eDrop  = 0;
    if (reset) begin
      qSlot.delete(); qLen.delete(); qErr.delete();
      mHead = 0; mFill = 0; mPkt = '0; mDrop = '0;
    end else begin
      wasFill = mFill;
      size = qSlot.size();
      tail = (mHead + size) % SLOTS;
      if (!wasFill && cap_req) begin
        if (enable && size < SLOTS) begin
          eGrant = 1; eAddr = slotAddr(tail); mFill = 1;
        end else begin
          eDrop = 1;
          if (mDrop != 32'hFFFF_FFFF) mDrop = mDrop + 1;
        end
      end
      if (wasFill && cap_done) begin
        l = int'(cap_len); e = int'(cap_err);
        if (l > SB) begin l = SB; e = 1; end
        qSlot.push_back(tail); qLen.push_back(l); qErr.push_back(e);
        mPkt = mPkt + 1;
        mFill = 0;
      end else if (wasFill && cap_abort) begin
        mFill = 0;
      end
      if (sw_pop && size != 0) begin
        void'(qSlot.pop_front()); void'(qLen.pop_front()); void'(qErr.pop_front());
        mHead = (mHead + 1) % SLOTS;
      end
    end
    @(negedge clk);
    checkOutput("cap_grant", 32'(cap_grant), 32'(eGrant));
    checkOutput("cap_drop", 32'(cap_drop), 32'(eDrop));
    checkOutput("sw_valid", 32'(sw_valid), 32'(qSlot.size() != 0));
    checkOutput("ready_count", 32'(ready_count), 32'(qSlot.size()));
    checkOutput("pkt_count", pkt_count, mPkt);
    checkOutput("drop_count", drop_count, mDrop);
    if (reset) checkOutput("cap_addr_reset", cap_addr, BASE);
    if (eGrant) checkOutput("cap_addr", cap_addr, eAddr);
    if (qSlot.size() != 0) begin
      checkOutput("sw_addr", sw_addr, slotAddr(qSlot[0]));
      checkOutput("sw_len", 32'(sw_len), 32'(qLen[0]));
      checkOutput("sw_err", 32'(sw_err), 32'(qErr[0]));
    end
    cap_req = 0; cap_done = 0; cap_abort = 0; sw_pop = 0;
  endtask

  task automatic doPacket(input int len, input bit err);
    cap_req = 1; applyStimulus();
    cap_done = 1; cap_len = 12'(len); cap_err = err; applyStimulus();
  endtask

  initial begin
    reset = 1; enable = 0; cap_req = 0; cap_done = 0; cap_abort = 0;
    cap_len = '0; cap_err = 0; sw_pop = 0;
    mHead = 0; mFill = 0; mPkt = '0; mDrop = '0; eAddr = BASE;
    @(negedge clk);
    applyStimulus(); applyStimulus();
    reset = 0; enable = 1;
    $display("[TB] first grant and completion");
    cap_req = 1; applyStimulus();
    checkOutput("firstGrant", 32'(cap_grant), 32'd1);
    checkOutput("firstGrantAddr", cap_addr, 32'h1000_0000);
    cap_done = 1; cap_len = 12'd64; applyStimulus();
    checkOutput("firstSwLen", 32'(sw_len), 32'd64);
    checkOutput("firstPkt", pkt_count, 32'd1);

    $display("[TB] fill ring, drop on full, wrap to slot 0");
    for (int i = 1; i < SLOTS; i++) doPacket(100 + i, i[0]);
    checkOutput("fullCount", 32'(ready_count), 32'd16);
    cap_req = 1; applyStimulus();
    checkOutput("fullDropCount", drop_count, 32'd1);
    sw_pop = 1; applyStimulus();
    cap_req = 1; applyStimulus();
    checkOutput("wrapAddr", cap_addr, 32'h1000_0000);
    cap_done = 1; cap_len = 12'd3000; cap_err = 0; applyStimulus();
    doPacket(2048, 0);
    while (qSlot.size() > 1) begin sw_pop = 1; applyStimulus(); end
    checkOutput("clampLen", 32'(sw_len), 32'd2048);
    checkOutput("clampErr", 32'(sw_err), 32'd1);
    sw_pop = 1; applyStimulus();

    $display("[TB] disabled requests, enable drop mid-fill, abort");
    reset = 1; applyStimulus(); reset = 0;
    enable = 0;
    for (int i = 0; i < 3; i++) begin cap_req = 1; applyStimulus(); end
    checkOutput("disabledDrops", drop_count, 32'd3);
    enable = 1; cap_req = 1; applyStimulus();
    enable = 0; applyStimulus();
    cap_done = 1; cap_len = 12'd200; cap_err = 0; applyStimulus();
    enable = 1;
    cap_req = 1; applyStimulus();
    savedAddr = cap_addr;
    cap_abort = 1; applyStimulus();
    cap_req = 1; applyStimulus();
    checkOutput("abortReuse", cap_addr, savedAddr);
    cap_done = 1; cap_abort = 1; cap_len = 12'd300; applyStimulus();

    $display("[TB] simultaneous done and pop, pop when empty");
    savedAddr = sw_addr;
    cap_req = 1; applyStimulus();
    cap_done = 1; cap_len = 12'd400; sw_pop = 1; applyStimulus();
    checkOutput("donePopCount", 32'(ready_count), 32'd2);
    checkOutput("donePopAddr", sw_addr, savedAddr + 32'd2048);
    sw_pop = 1; applyStimulus();
    sw_pop = 1; applyStimulus();
    sw_pop = 1; applyStimulus();
    checkOutput("emptyPop", 32'(ready_count), 32'd0);

    $display("[TB] reset during fill");
    cap_req = 1; applyStimulus();
    reset = 1; applyStimulus(); reset = 0;
    cap_done = 1; cap_len = 12'd500; applyStimulus();
    checkOutput("lateDonePkt", pkt_count, 32'd0);
    cap_req = 1; applyStimulus();
    checkOutput("postResetAddr", cap_addr, BASE);
    cap_done = 1; applyStimulus();

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      cap_req   = ($urandom_range(0, 2) == 0);
      cap_done  = ($urandom_range(0, 3) == 0);
      cap_abort = ($urandom_range(0, 5) == 0);
      cap_len   = 12'($urandom_range(0, 4095));
      cap_err   = ($urandom_range(0, 7) == 0);
      sw_pop    = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
